restoring_divider_8_bits_sequential: RTL and testbench

//  Sequential unsigned 8-bit restoring divider: Q = A / B, R = A % B, one quotient bit per clock.

---
 rtl/restoring_divider_8_bits_sequential.sv | 159 +++++++++++++++
 tb/tb_restoring_divider_8_bits_sequential.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_8_bits_sequential.sv
// Sequential 8-bit restoring divider (one quotient bit per clock) and its 8-bit ripple subtractor.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operands and results.

module full_subtractor_8_bits_structure (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       BIN,
    output logic [7:0] S,
    output logic       BOUT
);
    logic [8:0] borrow;

    assign borrow[0] = BIN;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign S[i]        = A[i] ^ B[i] ^ borrow[i];
        assign borrow[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
    end

    assign BOUT = borrow[8];
endmodule

// state | meaning
// IDLE  | waiting for START; operands captured on the accepting edge
// RUN   | one restoring step per clock, dividend MSB first
// FIN   | DONE pulse; Q/R/DIV_ZERO valid
module restoring_divider_8_bits_sequential #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [N_BITS-1:0] A,
    input  logic [N_BITS-1:0] B,
    output logic              BUSY,
    output logic              DONE,
    output logic [N_BITS-1:0] Q,
    output logic [N_BITS-1:0] R,
    output logic              DIV_ZERO
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state, state_nxt;
    logic [N_BITS-1:0] dvd, dsr, p, quo;
    logic [CNT_W-1:0]  cnt;

    logic [N_BITS-1:0] a_mag, b_mag;
    logic [N_BITS-1:0] p_sh, p_nxt, quo_nxt, diff, q_res, r_res;
    logic              p8, bout, take, last;

    full_subtractor_8_bits_structure u_sub (
        .A    (p_sh),
        .B    (dsr),
        .BIN  (1'b0),
        .S    (diff),
        .BOUT (bout)
    );

    // p8 is the bit shifted out of P; when set the 9-bit value always exceeds the divisor
    assign p8      = p[N_BITS-1];
    assign p_sh    = {p[N_BITS-2:0], dvd[N_BITS-1]};
    assign take    = p8 | ~bout;
    assign p_nxt   = take ? diff : p_sh;
    assign quo_nxt = {quo[N_BITS-2:0], take};
    assign last    = (cnt == '0);

`ifdef DIVIDER_SIGNED_EN
    logic neg_q, neg_r;

    assign a_mag = A[N_BITS-1] ? ('0 - A) : A;
    assign b_mag = B[N_BITS-1] ? ('0 - B) : B;
    assign q_res = neg_q ? ('0 - quo_nxt) : quo_nxt;
    assign r_res = neg_r ? ('0 - p_nxt) : p_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && START) begin
            neg_q <= A[N_BITS-1] ^ B[N_BITS-1];
            neg_r <= A[N_BITS-1];
        end
    end
`else
    assign a_mag = A;
    assign b_mag = B;
    assign q_res = quo_nxt;
    assign r_res = p_nxt;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = (B == '0) ? FIN : RUN;
            RUN:     if (last)  state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            RUN:     BUSY = 1'b1;
            FIN:     DONE = 1'b1;
            default: ;
        endcase
    end

    // results are only written at completion so they hold across the next operation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dvd      <= '0;
            dsr      <= '0;
            p        <= '0;
            quo      <= '0;
            cnt      <= '0;
            Q        <= '0;
            R        <= '0;
            DIV_ZERO <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        dvd <= a_mag;
                        dsr <= b_mag;
                        p   <= '0;
                        quo <= '0;
                        cnt <= CNT_W'(N_BITS - 1);
                        if (B == '0) begin
                            Q        <= '1;
                            R        <= A;
                            DIV_ZERO <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[N_BITS-2:0], 1'b0};
                    p   <= p_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        Q        <= q_res;
                        R        <= r_res;
                        DIV_ZERO <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider_8_bits_sequential.sv
// Self-checking bench for restoring_divider_8_bits_sequential: vector table plus handshake corner cases.
module tb_restoring_divider_8_bits_sequential;
    logic       CLK = 1'b0;
    logic       RST, START;
    logic [7:0] A, B, Q, R;
    logic       BUSY, DONE, DIV_ZERO;

    always #5 CLK = ~CLK;

    restoring_divider_8_bits_sequential dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .A        (A),
        .B        (B),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .Q        (Q),
        .R        (R),
        .DIV_ZERO (DIV_ZERO)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
        int         busy;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        if (b == 8'd0) begin
            v.q  = 8'hFF;
            v.r  = a;
            v.dz = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            int sa, sd;
            sa  = int'($signed(a));
            sd  = int'($signed(b));
            v.q = 8'(sa / sd);
            v.r = 8'(sa % sd);
`else
            v.q = a / b;
            v.r = a % b;
`endif
            v.dz = 1'b0;
        end
        return v;
    endfunction

    // Caller must be at a negedge; START is driven immediately.
    task automatic run_op(input vec_t v, input int inj_at, input int rst_at);
        exp_t e;
        exp_t got;
        int   busy_cnt;
        int   lat;
        int   dones;
        bit   done_seen;
        A      = v.a;
        B      = v.b;
        START  = 1'b1;
        e.q    = v.q;
        e.r    = v.r;
        e.dz   = v.dz;
        e.lat  = (v.b == 8'd0) ? 1 : 9;
        e.busy = (v.b == 8'd0) ? 0 : 8;
        sb.push_back(e);
        busy_cnt  = 0;
        lat       = 0;
        done_seen = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) START = 1'b0;
            if (inj_at != 0 && cyc == inj_at) begin
                START = 1'b1;
                A     = ~v.a;
                B     = 8'h01;
            end
            if (inj_at != 0 && cyc == inj_at + 1) START = 1'b0;
            if (rst_at != 0 && cyc == rst_at) begin
                RST = 1'b1;
                #1;
                check("rst_busy", BUSY, 0);
                check("rst_done", DONE, 0);
                check("rst_q", Q, 0);
                check("rst_r", R, 0);
                check("rst_dz", DIV_ZERO, 0);
                void'(sb.pop_back());
                dones = 0;
                for (int k = 0; k < 14; k++) begin
                    @(negedge CLK);
                    if (k == 2) RST = 1'b0;
                    if (DONE) dones++;
                end
                check("rst_no_done", dones, 0);
                return;
            end
            if (BUSY) busy_cnt++;
            if (DONE) begin
                lat       = cyc;
                done_seen = 1'b1;
                break;
            end
        end
        check("done_seen", done_seen, 1);
        check("sb_depth", sb.size(), 1);
        got = sb.pop_front();
        if (done_seen) begin
            check("latency", lat, got.lat);
            check("busy_cycles", busy_cnt, got.busy);
            check("q", Q, got.q);
            check("r", R, got.r);
            check("div_zero", DIV_ZERO, got.dz);
        end
    endtask

    task automatic post_done();
        @(negedge CLK);
        check("done_pulse", DONE, 0);
        check("idle_busy", BUSY, 0);
    endtask

    initial begin
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back(vec_t'{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});
        vecs.push_back(vec_t'{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
        vecs.push_back(vec_t'{8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1});
        vecs.push_back(vec_t'{8'h64, 8'h03, 8'h21, 8'h01, 1'b0});
        vecs.push_back(vec_t'{8'h64, 8'hFD, 8'hDF, 8'h01, 1'b0});
`else
        vecs.push_back(vec_t'{8'd200, 8'd7, 8'h1C, 8'd4, 1'b0});
        vecs.push_back(vec_t'{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0});
        vecs.push_back(vec_t'{8'h0F, 8'h02, 8'h07, 8'h01, 1'b0});
        vecs.push_back(vec_t'{8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1});
        vecs.push_back(vec_t'{8'd100, 8'd3, 8'd33, 8'd1, 1'b0});
        vecs.push_back(vec_t'{8'h00, 8'h05, 8'h00, 8'h00, 1'b0});
        vecs.push_back(vec_t'{8'h05, 8'hC8, 8'h00, 8'h05, 1'b0});
        vecs.push_back(vec_t'{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0});
        vecs.push_back(vec_t'{8'h80, 8'h80, 8'h01, 8'h00, 1'b0});
        vecs.push_back(vec_t'{8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0});
        vecs.push_back(vec_t'{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1});
        vecs.push_back(vec_t'{8'hFE, 8'h81, 8'h01, 8'h7D, 1'b0});
`endif
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            vecs.push_back(model(ra, rb));
        end

        RST   = 1'b1;
        START = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (2) @(negedge CLK);
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        check("reset_q", Q, 0);
        check("reset_r", R, 0);
        check("reset_dz", DIV_ZERO, 0);
        RST = 1'b0;
        @(negedge CLK);

        run_op(model(8'd200, 8'd7), 0, 0);
        post_done();
        run_op(model(8'hFF, 8'h01), 0, 0);
        post_done();
        run_op(model(8'h0F, 8'h02), 0, 0);
        post_done();
        run_op(model(8'h5A, 8'h00), 0, 0);
        post_done();
        run_op(model(8'd100, 8'd3), 3, 0);
        post_done();
        run_op(model(8'd100, 8'd3), 0, 4);

        foreach (vecs[i]) begin
            run_op(vecs[i], 0, 0);
            post_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
